uart_tx_scheduler: RTL and testbench

- Sequences the single shared UART transmitter between two requesters:
  - Command-acknowledge frames, triggered by each decoded rx command byte.
  - Periodic status frames, default every 2 s at 50 MHz.
- Sits between the LED command decoder and the UART TX core. Replaces ad-hoc periodic echo logic.
- Drives one byte per handshake and never drives bytes from two frames interleaved.

---
 rtl/smarthome_pkg.sv | 31 +++
 rtl/period_tick_gen.sv | 31 +++
 rtl/uart_tx_scheduler.sv | 172 +++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/smarthome_pkg.sv
// Shared definitions for the smart-home UART reporting path: scheduler
// states, frame headers/lengths and the frame checksum helper.
package smarthome_pkg;

  // Scheduler FSM states.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ACK_SEND  = 2'd1,
    STAT_SEND = 2'd2
  } state_e;

  // Frame header bytes.
  localparam logic [7:0] ACK_HDR  = 8'hAC;
  localparam logic [7:0] STAT_HDR = 8'h55;

  // Frame lengths in bytes.
  localparam int unsigned ACK_LEN  = 2;
  localparam int unsigned STAT_LEN = 4;

  // Index of the final byte of each frame, sized for the byte index register.
  localparam logic [1:0] ACK_LAST_IDX  = 2'(ACK_LEN - 1);
  localparam logic [1:0] STAT_LAST_IDX = 2'(STAT_LEN - 1);

  // Status frame checksum: XOR of the three preceding bytes.
  function automatic logic [7:0] frame_checksum(input logic [7:0] b0,
                                                input logic [7:0] b1,
                                                input logic [7:0] b2);
    frame_checksum = b0 ^ b1 ^ b2;
  endfunction

endpackage

// File: rtl/period_tick_gen.sv
// Free-running period counter producing a one-cycle tick every
// PERIOD_CYCLES clock cycles. Reusable for any timed reporting.
module period_tick_gen #(
  parameter int PERIOD_CYCLES = 100000000,
  parameter int CNT_W         = 27
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PERIOD_CYCLES - 1);
  localparam logic [CNT_W-1:0] ZERO_CNT = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE_CNT  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_r;

  // Count 0..PERIOD_CYCLES-1 and wrap, independent of any consumer.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= ZERO_CNT;
    end else if (cnt_r == LAST_CNT) begin
      cnt_r <= ZERO_CNT;
    end else begin
      cnt_r <= cnt_r + ONE_CNT;
    end
  end

  assign tick = (cnt_r == LAST_CNT);

endmodule

// File: rtl/uart_tx_scheduler.sv
// Arbitrates the single UART transmitter between command-acknowledge
// frames (one per decoded rx command) and periodic status frames.
// Frames are snapshotted at start so bytes of two frames never interleave;
// a fairness flag makes status win after an ack when both are pending.
module uart_tx_scheduler
  import smarthome_pkg::*;
#(
  parameter int PERIOD_CYCLES = 100000000,
  parameter int CNT_W         = 27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] led_state,
  input  logic [7:0] rxdata,
  input  logic       rx_cmd_valid,
  input  logic       tx_ready,
  output logic [7:0] txdata,
  output logic       dataValid,
  output logic       busy,
  output logic       ack_drop
);

  logic            tick_s;
  logic            start_ack_s;
  logic            start_stat_s;

  state_e          state_r;
  logic [3:0][7:0] frame_r;
  logic [1:0]      idx_r;
  logic [1:0]      last_idx_r;
  logic            fair_r;

  logic [7:0]      ack_cmd_r;
  logic            ack_pend_r;
  logic            stat_pend_r;
  logic [7:0]      last_cmd_r;

  logic [7:0]      txdata_r;
  logic            data_valid_r;
  logic            busy_r;
  logic            ack_drop_r;

  period_tick_gen #(
    .PERIOD_CYCLES (PERIOD_CYCLES),
    .CNT_W         (CNT_W)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick_s)
  );

  // Decide which frame (if any) starts at the next edge from IDLE.
  always_comb begin
    start_ack_s  = 1'b0;
    start_stat_s = 1'b0;
    if (state_r == IDLE) begin
      if (ack_pend_r && !(fair_r && stat_pend_r)) begin
        start_ack_s = 1'b1;
      end else if (stat_pend_r) begin
        start_stat_s = 1'b1;
      end else begin
        start_ack_s  = 1'b0;
        start_stat_s = 1'b0;
      end
    end else begin
      start_ack_s  = 1'b0;
      start_stat_s = 1'b0;
    end
  end

  // Capture rx commands; a new command over an unstarted ack drops the old one.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_cmd_r  <= 8'h00;
      ack_pend_r <= 1'b0;
      last_cmd_r <= 8'h00;
      ack_drop_r <= 1'b0;
    end else begin
      ack_drop_r <= rx_cmd_valid && ack_pend_r && !start_ack_s;
      if (rx_cmd_valid) begin
        ack_cmd_r  <= rxdata;
        ack_pend_r <= 1'b1;
        last_cmd_r <= rxdata;
      end else if (start_ack_s) begin
        ack_pend_r <= 1'b0;
      end else begin
        ack_pend_r <= ack_pend_r;
      end
    end
  end

  // Latch status requests from the period tick; repeated ticks coalesce.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_pend_r <= 1'b0;
    end else if (start_stat_s) begin
      stat_pend_r <= 1'b0;
    end else if (tick_s) begin
      stat_pend_r <= 1'b1;
    end else begin
      stat_pend_r <= stat_pend_r;
    end
  end

  // Frame sequencer: snapshot a frame on start, then hand out one byte per ready cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      frame_r      <= {4{8'h00}};
      idx_r        <= 2'd0;
      last_idx_r   <= 2'd0;
      fair_r       <= 1'b0;
      txdata_r     <= 8'h00;
      data_valid_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      data_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start_ack_s) begin
            frame_r[0] <= ACK_HDR;
            frame_r[1] <= ack_cmd_r;
            frame_r[2] <= 8'h00;
            frame_r[3] <= 8'h00;
            idx_r      <= 2'd0;
            last_idx_r <= ACK_LAST_IDX;
            state_r    <= ACK_SEND;
            busy_r     <= 1'b1;
          end else if (start_stat_s) begin
            frame_r[0] <= STAT_HDR;
            frame_r[1] <= {4'h0, led_state};
            frame_r[2] <= last_cmd_r;
            frame_r[3] <= frame_checksum(STAT_HDR, {4'h0, led_state}, last_cmd_r);
            idx_r      <= 2'd0;
            last_idx_r <= STAT_LAST_IDX;
            state_r    <= STAT_SEND;
            busy_r     <= 1'b1;
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        ACK_SEND, STAT_SEND: begin
          if (tx_ready) begin
            txdata_r     <= frame_r[idx_r];
            data_valid_r <= 1'b1;
            idx_r        <= idx_r + 2'd1;
            if (idx_r == last_idx_r) begin
              state_r <= IDLE;
              busy_r  <= 1'b0;
              fair_r  <= (state_r == ACK_SEND);
            end else begin
              state_r <= state_r;
            end
          end else begin
            idx_r <= idx_r;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign txdata    = txdata_r;
  assign dataValid = data_valid_r;
  assign busy      = busy_r;
  assign ack_drop  = ack_drop_r;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler with PERIOD_CYCLES=16.
// Stimulus pushes hand-computed frame bytes; a negedge monitor pops and
// compares every dataValid strobe.
module tb_uart_tx_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] led_state;
  logic [7:0] rxdata;
  logic       rx_cmd_valid;
  logic       tx_ready;
  logic [7:0] txdata;
  logic       dataValid;
  logic       busy;
  logic       ack_drop;

  int checks   = 0;
  int failures = 0;
  int strobes  = 0;
  int drops    = 0;
  logic [7:0] exp_q[$];
  logic       ready_q = 1'b0;

  uart_tx_scheduler #(
    .PERIOD_CYCLES (16),
    .CNT_W         (5)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .led_state    (led_state),
    .rxdata       (rxdata),
    .rx_cmd_valid (rx_cmd_valid),
    .tx_ready     (tx_ready),
    .txdata       (txdata),
    .dataValid    (dataValid),
    .busy         (busy),
    .ack_drop     (ack_drop)
  );

  always #5 clk = ~clk;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // tx_ready as seen by the DUT at the edge that produced the current outputs
  always @(posedge clk) ready_q <= tx_ready;

  // Monitor: every strobe must match the head of the expected queue
  always @(negedge clk) begin
    if (ack_drop === 1'b1) drops++;
    if (dataValid === 1'b1) begin
      strobes++;
      check("strobe_with_ready", {31'd0, ready_q}, 32'd1);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_byte: got %0h expected no strobe", txdata);
      end else begin
        check("txdata", {24'd0, txdata}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leaves time just after the last reset edge; the next edge is E0
  task automatic do_reset();
    rst = 1'b1;
    rx_cmd_valid = 1'b0;
    rxdata = 8'h00;
    tx_ready = 1'b1;
    step(2);
    check("rst_txdata", {24'd0, txdata}, 32'd0);
    check("rst_dataValid", {31'd0, dataValid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ack_drop", {31'd0, ack_drop}, 32'd0);
    exp_q.delete();
    strobes = 0;
    drops = 0;
    rst = 1'b0;
  endtask

  task automatic push4(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic [7:0] d);
    exp_q.push_back(a);
    exp_q.push_back(b);
    exp_q.push_back(c);
    exp_q.push_back(d);
  endtask

  initial begin
    led_state = 4'b0101;
    rst = 1'b1;
    rx_cmd_valid = 1'b0;
    rxdata = 8'h00;
    tx_ready = 1'b1;

    // 1: first status frame after the first tick
    do_reset();
    push4(8'h55, 8'h05, 8'h00, 8'h50);
    step(16);
    check("s1_busy_before", {31'd0, busy}, 32'd0);
    check("s1_dv_before", {31'd0, dataValid}, 32'd0);
    step(1);
    check("s1_busy_start", {31'd0, busy}, 32'd1);
    step(1);
    check("s1_dv_first", {31'd0, dataValid}, 32'd1);
    step(3);
    check("s1_busy_end", {31'd0, busy}, 32'd0);
    check("s1_dv_last", {31'd0, dataValid}, 32'd1);
    step(1);
    check("s1_dv_after", {31'd0, dataValid}, 32'd0);
    step(1);
    check("s1_queue_empty", exp_q.size(), 32'd0);

    // 2: single command ack, then status carries last_cmd
    do_reset();
    rxdata = 8'd22;
    rx_cmd_valid = 1'b1;
    exp_q.push_back(8'hAC);
    exp_q.push_back(8'h16);
    step(1);
    rx_cmd_valid = 1'b0;
    step(1);
    check("s2_dv_latency", {31'd0, dataValid}, 32'd0);
    check("s2_busy", {31'd0, busy}, 32'd1);
    step(1);
    check("s2_dv_first", {31'd0, dataValid}, 32'd1);
    step(1);
    push4(8'h55, 8'h05, 8'h16, 8'h46);
    step(18);
    check("s2_drops", drops, 32'd0);
    check("s2_queue_empty", exp_q.size(), 32'd0);

    // 3: two commands during a status frame, second overwrites first
    do_reset();
    push4(8'h55, 8'h05, 8'h00, 8'h50);
    exp_q.push_back(8'hAC);
    exp_q.push_back(8'h15);
    step(17);
    rxdata = 8'd20;
    rx_cmd_valid = 1'b1;
    step(1);
    rxdata = 8'd21;
    step(1);
    rx_cmd_valid = 1'b0;
    check("s3_ack_drop_pulse", {31'd0, ack_drop}, 32'd1);
    step(1);
    check("s3_ack_drop_clear", {31'd0, ack_drop}, 32'd0);
    step(5);
    check("s3_drops", drops, 32'd1);
    check("s3_queue_empty", exp_q.size(), 32'd0);

    // 4: command coincides with tick (ack first), later command waits for status
    do_reset();
    exp_q.push_back(8'hAC);
    exp_q.push_back(8'h31);
    push4(8'h55, 8'h05, 8'h32, 8'h62);
    exp_q.push_back(8'hAC);
    exp_q.push_back(8'h32);
    step(15);
    rxdata = 8'h31;
    rx_cmd_valid = 1'b1;
    step(1);
    rx_cmd_valid = 1'b0;
    step(1);
    check("s4_busy", {31'd0, busy}, 32'd1);
    rxdata = 8'h32;
    rx_cmd_valid = 1'b1;
    step(1);
    rx_cmd_valid = 1'b0;
    step(10);
    check("s4_drops", drops, 32'd0);
    check("s4_queue_empty", exp_q.size(), 32'd0);

    // 5: tx_ready toggling 1,0,0 during a status frame
    do_reset();
    push4(8'h55, 8'h05, 8'h00, 8'h50);
    step(17);
    for (int i = 0; i < 12; i++) begin
      tx_ready = ((i % 3) == 0);
      step(1);
    end
    tx_ready = 1'b1;
    check("s5_strobes", strobes, 32'd4);
    check("s5_queue_empty", exp_q.size(), 32'd0);

    // 6: reset after two bytes of a status frame
    do_reset();
    exp_q.push_back(8'h55);
    exp_q.push_back(8'h05);
    step(19);
    rst = 1'b1;
    step(1);
    check("s6_dv_after_rst", {31'd0, dataValid}, 32'd0);
    check("s6_busy_after_rst", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    check("s6_queue_after_rst", exp_q.size(), 32'd0);
    push4(8'h55, 8'h05, 8'h00, 8'h50);
    step(16);
    check("s6_busy_before_tick", {31'd0, busy}, 32'd0);
    step(1);
    check("s6_busy_restart", {31'd0, busy}, 32'd1);
    check("s6_dv_restart", {31'd0, dataValid}, 32'd0);
    step(1);
    check("s6_dv_first", {31'd0, dataValid}, 32'd1);
    step(5);
    check("s6_queue_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
